// File: rtl/cpu_core_param.sv
// cpu_core_param -- parametrised multi-cycle CPU core.
//
// Fetches one instruction at a time over a valid-qualified instruction-memory
// handshake and runs it through IDLE/FETCH/EXEC/MEM. It has a 16-entry
// register file, an internal data memory with a registered read port and a
// hardware return stack. HALT and traps (illegal opcode, stack overflow, stack
// underflow) park the core until reset.
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   imem_req    fetch request, high exactly while in FETCH
//   imem_addr   fetch address (equals pc)
//   imem_rdata  instruction word, taken when imem_req && imem_valid
//   imem_valid  instruction-return strobe
//   pc          program counter
//   retired     one-cycle pulse per completed instruction
//   halted      sticky, set by HALT
//   trap        sticky, set by a trap
//   trap_cause  01 illegal opcode, 10 stack overflow, 11 stack underflow
//   dbg_raddr   debug register-file read index
//   dbg_rdata   combinational read of register dbg_raddr
module cpu_core_param #(
  parameter int DATA_W      = 19,
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 16,
  localparam int INSTR_W    = 13 + ADDR_W
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               retired,
  output logic               halted,
  output logic               trap,
  output logic [1:0]         trap_cause,
  input  logic [3:0]         dbg_raddr,
  output logic [DATA_W-1:0]  dbg_rdata
);

  // sp counts 0..STACK_DEPTH, so it needs one bit more than the stack index.
  localparam int SP_W = $clog2(STACK_DEPTH) + 1;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_NOT  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_INC  = 5'b01000;
  localparam logic [4:0] OP_DEC  = 5'b01001;
  localparam logic [4:0] OP_LDI  = 5'b01010;
  localparam logic [4:0] OP_LD   = 5'b10000;
  localparam logic [4:0] OP_ST   = 5'b10001;
  localparam logic [4:0] OP_JMP  = 5'b11000;
  localparam logic [4:0] OP_BEQ  = 5'b11001;
  localparam logic [4:0] OP_BNE  = 5'b11010;
  localparam logic [4:0] OP_CALL = 5'b11011;
  localparam logic [4:0] OP_RET  = 5'b11100;
  localparam logic [4:0] OP_HALT = 5'b11101;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALTED, S_TRAP
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [INSTR_W-1:0]  r_instr;
  logic [SP_W-1:0]     r_sp;
  logic                r_imem_req;
  logic                r_retired;
  logic                r_halted;
  logic                r_trap;
  logic [1:0]          r_trap_cause;
  logic [DATA_W-1:0]   r_regs  [16];
  logic [DATA_W-1:0]   r_dmem  [2**ADDR_W];
  logic [DATA_W-1:0]   r_dmem_q;
  logic [ADDR_W-1:0]   r_stack [STACK_DEPTH];

  // Instruction fields of the latched instruction.
  logic [4:0]          w_op;
  logic [3:0]          w_r1;
  logic [3:0]          w_r2;
  logic [3:0]          w_r3;
  logic [ADDR_W-1:0]   w_fld;
  logic [DATA_W-1:0]   w_rd1;
  logic [DATA_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_b;

  assign w_op  = r_instr[INSTR_W-1 -: 5];
  assign w_r1  = r_instr[ADDR_W+7 -: 4];
  assign w_r2  = r_instr[ADDR_W+3 -: 4];
  assign w_fld = r_instr[ADDR_W-1:0];
  assign w_r3  = w_fld[ADDR_W-1 -: 4];
  assign w_rd1 = r_regs[w_r1];
  assign w_a   = r_regs[w_r2];
  assign w_b   = r_regs[w_r3];

  logic [ADDR_W-1:0]   w_pc_inc;
  logic                w_full;
  logic                w_empty;
  logic [SP_W-1:0]     w_sp_dec;
  logic [ADDR_W-1:0]   w_ret_addr;

  assign w_pc_inc   = r_pc + ADDR_W'(1);
  assign w_full     = (r_sp == SP_W'(STACK_DEPTH));
  assign w_empty    = (r_sp == '0);
  assign w_sp_dec   = r_sp - SP_W'(1);
  assign w_ret_addr = r_stack[w_sp_dec[SP_W-2:0]];

  // ALU result for register-writing ops.
  logic [DATA_W-1:0]   w_alu_res;
  logic                w_alu_wr;

  always_comb begin
    w_alu_res = '0;
    w_alu_wr  = 1'b1;
    case (w_op)
      OP_ADD:  w_alu_res = w_a + w_b;
      OP_SUB:  w_alu_res = w_a - w_b;
      OP_AND:  w_alu_res = w_a & w_b;
      OP_OR:   w_alu_res = w_a | w_b;
      OP_XOR:  w_alu_res = w_a ^ w_b;
      OP_NOT:  w_alu_res = ~w_a;
      OP_SHL:  w_alu_res = w_a << 1;
      OP_SHR:  w_alu_res = w_a >> 1;
      OP_INC:  w_alu_res = w_a + DATA_W'(1);
      OP_DEC:  w_alu_res = w_a - DATA_W'(1);
      OP_LDI:  w_alu_res = DATA_W'(w_fld);
      default: w_alu_wr  = 1'b0;
    endcase
  end

  // Control decode: next pc, stack movement and trap detection for EXEC.
  logic [ADDR_W-1:0]   w_next_pc;
  logic                w_trap;
  logic [1:0]          w_cause;
  logic                w_halt;
  logic                w_is_ld;
  logic                w_push;
  logic                w_pop;

  always_comb begin
    w_next_pc = w_pc_inc;
    w_trap    = 1'b0;
    w_cause   = 2'b00;
    w_halt    = 1'b0;
    w_is_ld   = 1'b0;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    case (w_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
      OP_SHL, OP_SHR, OP_INC, OP_DEC, OP_LDI, OP_ST: ;
      OP_LD:   w_is_ld = 1'b1;
      OP_JMP:  w_next_pc = w_fld;
      OP_BEQ:  if (w_rd1 == w_a) w_next_pc = w_fld;
      OP_BNE:  if (w_rd1 != w_a) w_next_pc = w_fld;
      OP_CALL: begin
        if (w_full) begin
          w_trap  = 1'b1;
          w_cause = 2'b10;
        end else begin
          w_push    = 1'b1;
          w_next_pc = w_fld;
        end
      end
      OP_RET: begin
        if (w_empty) begin
          w_trap  = 1'b1;
          w_cause = 2'b11;
        end else begin
          w_pop     = 1'b1;
          w_next_pc = w_ret_addr;
        end
      end
      OP_HALT: w_halt = 1'b1;
      default: begin
        w_trap  = 1'b1;
        w_cause = 2'b01;
      end
    endcase
  end

  logic w_in_exec;
  assign w_in_exec = (r_state == S_EXEC);

  // Data memory and return stack storage: no reset, so they map onto RAM.
  // Enables are derived from the state register, which the async reset
  // forces to IDLE, so nothing is written while reset is held.
  always_ff @(posedge clk) begin
    if (w_in_exec && (w_op == OP_ST))
      r_dmem[w_fld] <= w_rd1;
    if (w_in_exec && w_is_ld)
      r_dmem_q <= r_dmem[w_fld];
    if (w_in_exec && w_push)
      r_stack[r_sp[SP_W-2:0]] <= w_pc_inc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_instr      <= '0;
      r_sp         <= '0;
      r_imem_req   <= 1'b0;
      r_retired    <= 1'b0;
      r_halted     <= 1'b0;
      r_trap       <= 1'b0;
      r_trap_cause <= 2'b00;
      for (int i = 0; i < 16; i++)
        r_regs[i] <= '0;
    end else begin
      r_retired <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state    <= S_FETCH;
          r_imem_req <= 1'b1;
        end
        S_FETCH: begin
          if (imem_valid) begin
            r_instr    <= imem_rdata;
            r_imem_req <= 1'b0;
            r_state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_trap) begin
            // Faulting instruction leaves all architectural state alone.
            r_trap       <= 1'b1;
            r_trap_cause <= w_cause;
            r_state      <= S_TRAP;
          end else if (w_halt) begin
            r_halted <= 1'b1;
            r_state  <= S_HALTED;
          end else if (w_is_ld) begin
            r_state <= S_MEM;
          end else begin
            if (w_alu_wr)
              r_regs[w_r1] <= w_alu_res;
            if (w_push)
              r_sp <= r_sp + SP_W'(1);
            if (w_pop)
              r_sp <= w_sp_dec;
            r_pc       <= w_next_pc;
            r_retired  <= 1'b1;
            r_imem_req <= 1'b1;
            r_state    <= S_FETCH;
          end
        end
        S_MEM: begin
          r_regs[w_r1] <= r_dmem_q;
          r_pc         <= w_pc_inc;
          r_retired    <= 1'b1;
          r_imem_req   <= 1'b1;
          r_state      <= S_FETCH;
        end
        S_HALTED, S_TRAP: ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req   = r_imem_req;
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign retired    = r_retired;
  assign halted     = r_halted;
  assign trap       = r_trap;
  assign trap_cause = r_trap_cause;
  assign dbg_rdata  = r_regs[dbg_raddr];

endmodule

// File: tb/tb_cpu_core_param.sv
// Testbench for cpu_core_param: an instruction-level model steps once per
// accepted fetch, and a per-cycle check compares retire timing, fetch
// handshake, pc, sticky flags and the written register against it.
module tb_cpu_core_param;
  localparam int DW = 19;
  localparam int AW = 8;
  localparam int SD = 16;
  localparam int IW = 13 + AW;
  localparam int DMASK = (1 << DW) - 1;
  localparam int AMASK = (1 << AW) - 1;
  localparam int NEVER = 1 << 30;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata = '0;
  logic          imem_valid = 1'b0;
  logic [AW-1:0] pc;
  logic          retired, halted, trap;
  logic [1:0]    trap_cause;
  logic [3:0]    dbg_raddr = '0;
  logic [DW-1:0] dbg_rdata;

  always #5 clk = ~clk;

  cpu_core_param #(.DATA_W(DW), .ADDR_W(AW), .STACK_DEPTH(SD)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .pc(pc), .retired(retired), .halted(halted), .trap(trap),
    .trap_cause(trap_cause), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Program memory and the instruction-level model.
  int imem [256];
  int m_regs [16];
  int m_dmem [256];
  int m_stack [$];
  int m_pc, m_cause;
  bit m_halt, m_trap;

  // Run bookkeeping.
  int fetch_start, ret_cycle, stop_cycle;
  int n_acc, n_ret, max_acc, delay_mode, wait_left;
  bit stopped;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int enc(input int op, input int r1, input int r2, input int fld);
    return (op << (AW + 8)) | (r1 << (AW + 4)) | (r2 << AW) | (fld & AMASK);
  endfunction

  function automatic int enc3(input int op, input int rd, input int ra, input int rb);
    return enc(op, rd, ra, rb << (AW - 4));
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = enc(29, 0, 0, 0);
  endtask

  task automatic model_exec(input int ins, output bit is_ld, output bit stp);
    int op, r1, r2, r3, fld, a, b, nxt;
    op  = (ins >> (AW + 8)) & 31;
    r1  = (ins >> (AW + 4)) & 15;
    r2  = (ins >> AW) & 15;
    fld = ins & AMASK;
    r3  = fld >> (AW - 4);
    a   = m_regs[r2];
    b   = m_regs[r3];
    nxt = (m_pc + 1) & AMASK;
    is_ld = 0;
    stp = 0;
    case (op)
      0:  begin m_regs[r1] = (a + b) & DMASK; m_pc = nxt; end
      1:  begin m_regs[r1] = (a - b) & DMASK; m_pc = nxt; end
      2:  begin m_regs[r1] = a & b; m_pc = nxt; end
      3:  begin m_regs[r1] = a | b; m_pc = nxt; end
      4:  begin m_regs[r1] = a ^ b; m_pc = nxt; end
      5:  begin m_regs[r1] = (~a) & DMASK; m_pc = nxt; end
      6:  begin m_regs[r1] = (a * 2) & DMASK; m_pc = nxt; end
      7:  begin m_regs[r1] = a / 2; m_pc = nxt; end
      8:  begin m_regs[r1] = (a + 1) & DMASK; m_pc = nxt; end
      9:  begin m_regs[r1] = (a - 1) & DMASK; m_pc = nxt; end
      10: begin m_regs[r1] = fld; m_pc = nxt; end
      16: begin m_regs[r1] = m_dmem[fld]; m_pc = nxt; is_ld = 1; end
      17: begin m_dmem[fld] = m_regs[r1]; m_pc = nxt; end
      24: m_pc = fld;
      25: m_pc = (m_regs[r1] == m_regs[r2]) ? fld : nxt;
      26: m_pc = (m_regs[r1] != m_regs[r2]) ? fld : nxt;
      27: begin
        if (m_stack.size() == SD) begin m_trap = 1; m_cause = 2; stp = 1; end
        else begin m_stack.push_back(nxt); m_pc = fld; end
      end
      28: begin
        if (m_stack.size() == 0) begin m_trap = 1; m_cause = 3; stp = 1; end
        else m_pc = m_stack.pop_back();
      end
      29: begin m_halt = 1; stp = 1; end
      default: begin m_trap = 1; m_cause = 1; stp = 1; end
    endcase
  endtask

  function automatic int next_delay();
    return (delay_mode >= 0) ? delay_mode : int'($urandom_range(0, 2));
  endfunction

  // One cycle of checking (outputs as they stand after the last rising edge)
  // followed by driving the instruction-memory side for the next edge.
  task automatic step();
    bit exp_ret, exp_req, stop_now, is_ld, stp;
    int ins;
    exp_ret  = (cyc == ret_cycle);
    exp_req  = (cyc >= fetch_start);
    stop_now = stopped && (cyc >= stop_cycle);
    chk("retired", retired, exp_ret);
    chk("imem_req", imem_req, exp_req);
    chk("halted", halted, stop_now && m_halt);
    chk("trap", trap, stop_now && m_trap);
    if (stop_now && m_trap) chk("trap_cause", trap_cause, m_cause);
    if (exp_req || exp_ret || stop_now) chk("pc", pc, m_pc);
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    if (exp_ret) begin
      n_ret++;
      chk("dbg_rdata", dbg_rdata, m_regs[dbg_raddr]);
    end

    imem_valid = 1'b0;
    if (imem_req && n_acc < max_acc) begin
      if (wait_left > 0) wait_left--;
      else begin
        ins = imem[m_pc];
        imem_valid = 1'b1;
        imem_rdata = IW'(imem[imem_addr]);
        dbg_raddr = 4'((ins >> (AW + 4)) & 15);
        model_exec(ins, is_ld, stp);
        n_acc++;
        if (stp) begin
          stopped = 1;
          stop_cycle = cyc + 2;
          fetch_start = NEVER;
        end else begin
          ret_cycle = cyc + (is_ld ? 3 : 2);
          fetch_start = ret_cycle;
        end
        wait_left = next_delay();
      end
    end else if (!imem_req && $urandom_range(0, 3) == 0) begin
      // Strobe outside FETCH carrying junk must be ignored.
      imem_valid = 1'b1;
      imem_rdata = IW'($urandom);
    end
  endtask

  task automatic run_prog(input int max_i, input int dly);
    int t0;
    bit done;
    reset_n = 1'b0;
    imem_valid = 1'b0;
    dbg_raddr = 4'($urandom);
    @(negedge clk);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_retired", retired, 0);
    chk("rst_halted", halted, 0);
    chk("rst_trap", trap, 0);
    chk("rst_cause", trap_cause, 0);
    chk("rst_pc", pc, 0);
    chk("rst_reg", dbg_rdata, 0);
    for (int i = 0; i < 16; i++) m_regs[i] = 0;
    m_stack.delete();
    m_pc = 0; m_halt = 0; m_trap = 0; m_cause = 0;
    stopped = 0; n_acc = 0; n_ret = 0; max_acc = max_i; delay_mode = dly;
    wait_left = next_delay();
    ret_cycle = -1; stop_cycle = NEVER;
    @(negedge clk);
    reset_n = 1'b1;
    fetch_start = cyc + 1;
    t0 = cyc;
    done = 0;
    while (!done) begin
      @(negedge clk);
      step();
      if (stopped && cyc >= stop_cycle + 3) done = 1;
      else if (!stopped && n_acc >= max_acc && cyc >= fetch_start) done = 1;
      else if (cyc - t0 > 5000) begin
        chk("run_timeout", 1, 0);
        done = 1;
      end
    end
    imem_valid = 1'b0;
  endtask

  task automatic rd_reg(input int idx, output int v);
    dbg_raddr = 4'(idx);
    #1;
    v = int'(dbg_rdata);
  endtask

  int v, k;

  initial begin
    for (int i = 0; i < 256; i++) m_dmem[i] = 0;

    // LDI/ALU chain.
    clear_imem();
    imem[0] = enc(10, 1, 0, 5);
    imem[1] = enc(10, 2, 0, 3);
    imem[2] = enc3(0, 3, 1, 2);
    imem[3] = enc3(1, 4, 2, 1);
    run_prog(100, 0);
    rd_reg(3, v); chk("chain_r3", v, 8);
    rd_reg(4, v); chk("chain_r4", v, 'h7FFFE);
    chk("chain_model_r4", m_regs[4], 'h7FFFE);
    chk("chain_retired", n_ret, 4);
    chk("chain_pc", pc, 4);
    chk("chain_halted", halted, 1);

    // Memory round trip with three stall cycles per fetch.
    clear_imem();
    imem[0] = enc(10, 3, 0, 8);
    imem[1] = enc(17, 3, 0, 'h20);
    imem[2] = enc(16, 5, 0, 'h20);
    run_prog(100, 3);
    rd_reg(5, v); chk("mem_r5", v, 8);
    chk("mem_retired", n_ret, 3);
    chk("mem_pc", pc, 3);

    // Branches, ADD at the top address wrapping to 0.
    clear_imem();
    imem[0]    = enc(26, 7, 8, 'h50);
    imem[1]    = enc(10, 1, 0, 7);
    imem[2]    = enc(10, 2, 0, 7);
    imem[3]    = enc(25, 1, 2, 'h40);
    imem['h40] = enc(26, 1, 2, 'h10);
    imem['h41] = enc(10, 7, 0, 1);
    imem['h42] = enc(24, 0, 0, 'hFF);
    imem['hFF] = enc3(0, 6, 1, 2);
    run_prog(100, -1);
    chk("brA_pc", pc, 'h50);
    rd_reg(6, v); chk("brA_r6", v, 14);
    chk("brA_retired", n_ret, 9);

    // JMP at the top address back to 0.
    clear_imem();
    imem[0]    = enc(26, 7, 8, 'h50);
    imem[1]    = enc(10, 7, 0, 1);
    imem[2]    = enc(24, 0, 0, 'hFF);
    imem['hFF] = enc(24, 0, 0, 0);
    run_prog(100, -1);
    chk("brB_pc", pc, 'h50);
    chk("brB_retired", n_ret, 5);

    // Nested CALL x16 then RET x16.
    clear_imem();
    for (int i = 0; i < 16; i++) imem[4 * i] = enc(27, 0, 0, 4 * (i + 1));
    imem[64] = enc(28, 0, 0, 0);
    for (int i = 1; i < 16; i++) imem[4 * i + 1] = enc(28, 0, 0, 0);
    run_prog(200, -1);
    chk("stk_pc", pc, 1);
    chk("stk_retired", n_ret, 32);
    chk("stk_halted", halted, 1);

    // Seventeenth CALL overflows.
    imem[64] = enc(27, 0, 0, 'h80);
    run_prog(200, -1);
    chk("ovf_trap", trap, 1);
    chk("ovf_cause", trap_cause, 2);
    chk("ovf_pc", pc, 64);
    chk("ovf_retired", n_ret, 16);

    // RET on an empty stack underflows.
    clear_imem();
    imem[0] = enc(28, 0, 0, 0);
    run_prog(10, 0);
    chk("unf_cause", trap_cause, 3);
    chk("unf_pc", pc, 0);

    // Illegal opcode.
    clear_imem();
    imem[0] = enc(10, 1, 0, 1);
    imem[1] = enc(15, 0, 0, 0);
    run_prog(10, 0);
    chk("ill_trap", trap, 1);
    chk("ill_cause", trap_cause, 1);
    chk("ill_pc", pc, 1);
    chk("ill_req", imem_req, 0);
    chk("ill_retired", n_ret, 1);

    // Reset pulsed during MEM of an LD (dmem[0x20] holds 8 from above).
    clear_imem();
    imem[0] = enc(16, 1, 0, 'h20);
    reset_n = 1'b0; imem_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!imem_req && k < 10);
    chk("rm_req_seen", imem_req, 1);
    chk("rm_addr", imem_addr, 0);
    imem_valid = 1'b1;
    imem_rdata = IW'(imem[0]);
    @(negedge clk);
    imem_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    dbg_raddr = 4'd1;
    #1;
    chk("rm_req", imem_req, 0);
    chk("rm_retired", retired, 0);
    chk("rm_pc", pc, 0);
    chk("rm_halted", halted, 0);
    chk("rm_trap", trap, 0);
    chk("rm_r1", dbg_rdata, 0);
    @(negedge clk);
    chk("rm_r1_after", dbg_rdata, 0);
    chk("rm_retired_after", retired, 0);
    reset_n = 1'b1;
    #1;
    chk("rm_req_release", imem_req, 0);
    @(posedge clk);
    #1;
    chk("rm_first_req", imem_req, 1);
    chk("rm_first_addr", imem_addr, 0);

    // Randomised programs.
    for (int p = 0; p < 6; p++) begin
      int r;
      for (int i = 0; i < 8; i++) imem[i] = enc(17, i, 0, i);
      for (int i = 8; i < 256; i++) begin
        r = $urandom_range(0, 99);
        if (r < 45)      imem[i] = enc($urandom_range(0, 10), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, AMASK));
        else if (r < 55) imem[i] = enc(16, $urandom_range(0, 15), 0, $urandom_range(0, 7));
        else if (r < 62) imem[i] = enc(17, $urandom_range(0, 15), 0, $urandom_range(0, 7));
        else if (r < 72) imem[i] = enc($urandom_range(25, 26), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, AMASK));
        else if (r < 76) imem[i] = enc(24, 0, 0, $urandom_range(0, AMASK));
        else if (r < 84) imem[i] = enc(27, 0, 0, $urandom_range(0, AMASK));
        else if (r < 92) imem[i] = enc(28, 0, 0, 0);
        else if (r < 93) imem[i] = enc(29, 0, 0, 0);
        else if (r < 94) imem[i] = enc(30, 0, 0, 0);
        else             imem[i] = enc3($urandom_range(0, 4), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      end
      run_prog(150, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
